// File: rtl/bist_misr_analyzer.sv
// MISR response compactor for the BIST path: folds NUM_PATTERNS CUT responses
// into a signature and reports pass/fault against GOLDEN. Optional watchdog: BIST_MISR_TIMEOUT_EN.
module bist_misr_analyzer #(
  parameter int              WIDTH          = 4,
  parameter int              NUM_PATTERNS   = 15,
  parameter logic [WIDTH-1:0] POLY          = 4'b0011,
  parameter logic [WIDTH-1:0] SEED          = 4'h0,
  parameter logic [WIDTH-1:0] GOLDEN        = 4'h0,
  parameter int              TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fault_detected,
  output logic             timeout
);

  localparam int CNT_W = $clog2(NUM_PATTERNS + 1);

  if (WIDTH < 2)          begin : g_bad_width   $error("WIDTH must be >= 2");          end
  if (NUM_PATTERNS < 1)   begin : g_bad_npat    $error("NUM_PATTERNS must be >= 1");   end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout $error("TIMEOUT_CYCLES must be >= 1"); end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    misr_step = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ d;
  endfunction

`ifdef BIST_MISR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      signature      <= SEED;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fault_detected <= 1'b0;
`ifdef BIST_MISR_TIMEOUT_EN
      wd_cnt         <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // start beats a same-cycle resp_valid; that response is dropped
          if (start) begin
            state          <= COMPACT;
            count          <= '0;
            signature      <= SEED;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fault_detected <= 1'b0;
`ifdef BIST_MISR_TIMEOUT_EN
            wd_cnt         <= '0;
            timeout_q      <= 1'b0;
`endif
          end
        end

        COMPACT: begin
`ifdef BIST_MISR_TIMEOUT_EN
          if (wd_cnt == WD_W'(TIMEOUT_CYCLES)) begin
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            pass           <= 1'b0;
            fault_detected <= 1'b1;
            timeout_q      <= 1'b1;
          end else if (resp_valid) begin
            wd_cnt <= '0;
`else
          if (resp_valid) begin
`endif
            signature <= misr_step(signature, resp);
            count     <= count + 1'b1;
            if (count == CNT_W'(NUM_PATTERNS - 1)) state <= COMPARE;
          end
`ifdef BIST_MISR_TIMEOUT_EN
          else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        COMPARE: begin
          state          <= DONE;
          busy           <= 1'b0;
          done           <= 1'b1;
          pass           <= (signature == GOLDEN);
          fault_detected <= (signature != GOLDEN);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Randomized self-checking bench for bist_misr_analyzer; the reference folds
// responses as polynomial arithmetic modulo x^4+x+1.
module tb_bist_misr_analyzer;

  localparam logic [3:0] GOLD = 4'hA;

  logic       clk = 1'b0;
  logic       rst, start, resp_valid;
  logic [3:0] resp;
  logic [3:0] signature;
  logic       busy, done, pass, fault_detected, timeout;

  int n_vec = 0;
  int n_bad = 0;

  bist_misr_analyzer #(
    .WIDTH(4), .NUM_PATTERNS(4), .POLY(4'b0011), .SEED(4'h0),
    .GOLDEN(GOLD), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
    .signature(signature), .busy(busy), .done(done), .pass(pass),
    .fault_detected(fault_detected), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // signature * x + response, reduced modulo x^4 + x + 1 (0x13)
  function automatic logic [3:0] misr_fold(input logic [3:0] s, input logic [3:0] d);
    int t;
    t = int'(s) * 2;
    if (t >= 16) t = t ^ 'h13;
    return 4'(t) ^ d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_session(input logic [3:0] r [4], input int max_gap);
    logic [3:0] exp_sig;
    int gap;
    start = 1'b1; resp_valid = 1'($urandom_range(0, 1)); resp = 4'($urandom);
    tick();
    start = 1'b0;
    check_val("start_sig", 32'(signature), 32'h0);
    check_val("start_busy", 32'(busy), 32'h1);
    check_val("start_done", 32'(done), 32'h0);
    exp_sig = 4'h0;
    for (int i = 0; i < 4; i++) begin
      gap = int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        resp_valid = 1'b0; resp = 4'($urandom); start = 1'($urandom_range(0, 1));
        tick();
        check_val("gap_sig", 32'(signature), 32'(exp_sig));
        check_val("gap_busy", 32'(busy), 32'h1);
      end
      resp_valid = 1'b1; resp = r[i]; start = 1'($urandom_range(0, 1));
      tick();
      exp_sig = misr_fold(exp_sig, r[i]);
      check_val("acc_sig", 32'(signature), 32'(exp_sig));
      check_val("acc_busy", 32'(busy), 32'h1);
      check_val("acc_done", 32'(done), 32'h0);
    end
    start = 1'b0; resp_valid = 1'($urandom_range(0, 1)); resp = 4'($urandom);
    tick();
    check_val("cmp_done", 32'(done), 32'h1);
    check_val("cmp_busy", 32'(busy), 32'h0);
    check_val("cmp_pass", 32'(pass), 32'(exp_sig == GOLD));
    check_val("cmp_fault", 32'(fault_detected), 32'(exp_sig != GOLD));
    check_val("cmp_timeout", 32'(timeout), 32'h0);
    check_val("cmp_sig", 32'(signature), 32'(exp_sig));
    for (int k = 0; k < 2; k++) begin
      resp_valid = 1'b1; resp = 4'($urandom);
      tick();
      check_val("done_sig_hold", 32'(signature), 32'(exp_sig));
      check_val("done_hold", 32'(done), 32'h1);
    end
    resp_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] rs [4];
    logic [3:0] all_f [4];
    all_f = '{4'hF, 4'hF, 4'hF, 4'hF};

    rst = 1'b1; start = 1'b0; resp_valid = 1'b0; resp = 4'h0;
    tick(); tick();
    check_val("rst_sig", 32'(signature), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_done", 32'(done), 32'h0);
    check_val("rst_pass", 32'(pass), 32'h0);
    check_val("rst_fault", 32'(fault_detected), 32'h0);
    check_val("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;
    tick();

    run_session(all_f, 0);
    check_val("good_sig", 32'(signature), 32'hA);
    check_val("good_pass", 32'(pass), 32'h1);

    rs = '{4'hF, 4'hF, 4'hF, 4'hE};
    run_session(rs, 0);
    check_val("bad_sig", 32'(signature), 32'hB);
    check_val("bad_fault", 32'(fault_detected), 32'h1);

    run_session(all_f, 3);
    check_val("gap_pass", 32'(pass), 32'h1);

    for (int s = 0; s < 25; s++) begin
      if (s % 3 == 0) rs = all_f;
      else for (int i = 0; i < 4; i++) rs[i] = 4'($urandom);
      run_session(rs, 2);
    end

    // reset in the middle of a session
    start = 1'b1; tick(); start = 1'b0;
    resp_valid = 1'b1; resp = 4'h7; tick(); tick();
    resp_valid = 1'b0; rst = 1'b1; tick();
    check_val("mid_rst_sig", 32'(signature), 32'h0);
    check_val("mid_rst_busy", 32'(busy), 32'h0);
    check_val("mid_rst_done", 32'(done), 32'h0);
    rst = 1'b0; resp_valid = 1'b1; tick();
    check_val("post_rst_idle", 32'(busy), 32'h0);
    check_val("post_rst_sig", 32'(signature), 32'h0);
    resp_valid = 1'b0;
    run_session(all_f, 1);
    check_val("post_rst_pass", 32'(pass), 32'h1);

`ifdef BIST_MISR_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      resp_valid = 1'b1; resp = 4'h5; tick();
      resp_valid = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (done) seen = 1'b1;
      end
      check_val("to_seen", 32'(seen), 32'h1);
      check_val("to_timeout", 32'(timeout), 32'h1);
      check_val("to_fault", 32'(fault_detected), 32'h1);
      check_val("to_pass", 32'(pass), 32'h0);
      check_val("to_sig", 32'(signature), 32'h5);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
